conv_allocator: RTL and testbench

- Pairs streamed image pixels with convolution filter weights for a downstream multiply-accumulate unit.
- Holds a programmable window centre (x, y) and an odd filter size (1/3/5/7).
- Buffers up to 49 filter weights from the filter stream.
- For each accepted pixel inside the window, emits a registered (pixel, weight, tap index) pair; sits between the pixel/filter issue logic and the MAC array.

---
 rtl/conv_allocator_if.sv | 51 +++++
 rtl/conv_allocator.sv | 145 ++++++++++++++
 tb/tb_conv_allocator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/conv_allocator_if.sv
// Pixel/filter issue and MAC pair bus for conv_allocator.
// Optional ALLOC_MISS_COUNT_EN adds the miss_count output.
interface conv_allocator_if #(
    parameter int DATA_W  = 18,
    parameter int COORD_W = 8,
    parameter int CNT_W   = 13
);
    logic [COORD_W-1:0] issue_a_x;
    logic [COORD_W-1:0] issue_a_y;
    logic [DATA_W-1:0]  issue_a_data;
    logic               issue_a_blocked;
    logic [CNT_W-1:0]   filter_issue_counter;
    logic [DATA_W-1:0]  filter_data;
    logic               filter_blocked;
    logic [COORD_W-1:0] center_x_input;
    logic [COORD_W-1:0] center_y_input;
    logic               center_write_enable;
    logic [2:0]         filter_dim;
    logic               pair_valid;
    logic [DATA_W-1:0]  pair_pixel;
    logic [DATA_W-1:0]  pair_weight;
    logic [5:0]         pair_index;
    logic               pair_last;
    logic               miss;
    logic               filter_loaded;
`ifdef ALLOC_MISS_COUNT_EN
    logic [15:0]        miss_count;
`endif

    modport master (
        output issue_a_x, issue_a_y, issue_a_data, issue_a_blocked,
        output filter_issue_counter, filter_data, filter_blocked,
        output center_x_input, center_y_input, center_write_enable, filter_dim,
`ifdef ALLOC_MISS_COUNT_EN
        input  miss_count,
`endif
        input  pair_valid, pair_pixel, pair_weight, pair_index, pair_last,
        input  miss, filter_loaded
    );

    modport slave (
        input  issue_a_x, issue_a_y, issue_a_data, issue_a_blocked,
        input  filter_issue_counter, filter_data, filter_blocked,
        input  center_x_input, center_y_input, center_write_enable, filter_dim,
`ifdef ALLOC_MISS_COUNT_EN
        output miss_count,
`endif
        output pair_valid, pair_pixel, pair_weight, pair_index, pair_last,
        output miss, filter_loaded
    );
endinterface

// File: rtl/conv_allocator.sv
// Pairs in-window pixels with buffered filter weights for the MAC array.
// Optional ALLOC_MISS_COUNT_EN adds a saturating miss counter.
module conv_allocator #(
    parameter int DATA_W  = 18,
    parameter int COORD_W = 8,
    parameter int CNT_W   = 13
) (
    input logic             clk,
    input logic             rst,
    conv_allocator_if.slave bus
);
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [2:0]         dim_q, dim_d;
    logic [63:0]        valid_q, valid_d;
    logic [DATA_W-1:0]  weight_q [64];
    logic               pair_valid_q, pair_valid_d;
    logic [DATA_W-1:0]  pair_pixel_q, pair_pixel_d;
    logic [DATA_W-1:0]  pair_weight_q, pair_weight_d;
    logic [5:0]         pair_index_q, pair_index_d;
    logic               pair_last_q, pair_last_d;
    logic               miss_q, miss_d;

    logic [5:0]         taps;
    logic               wr_en;
    logic [5:0]         wr_idx;
    logic signed [COORD_W:0] dx, dy, r_s, dxr, dyr;
    logic               in_win;
    logic [5:0]         idx;
    logic [DATA_W-1:0]  rd_weight;
    logic               rd_valid;
    logic               loaded;

    assign taps   = {3'b000, dim_q} * {3'b000, dim_q};
    assign wr_en  = !bus.filter_blocked &&
                    (bus.filter_issue_counter < {{(CNT_W-6){1'b0}}, taps});
    assign wr_idx = bus.filter_issue_counter[5:0];

    // Coordinates are widened to signed so windows near the origin never wrap.
    assign r_s    = $signed({{(COORD_W-1){1'b0}}, dim_q[2:1]});
    assign dx     = $signed({1'b0, bus.issue_a_x}) - $signed({1'b0, cx_q});
    assign dy     = $signed({1'b0, bus.issue_a_y}) - $signed({1'b0, cy_q});
    assign dxr    = dx + r_s;
    assign dyr    = dy + r_s;
    assign in_win = (dx <= r_s) && (dx >= -r_s) && (dy <= r_s) && (dy >= -r_s);
    assign idx    = {3'b000, dyr[2:0]} * {3'b000, dim_q} + {3'b000, dxr[2:0]};

    // Same-cycle write to the tap being read is forwarded.
    assign rd_weight = (wr_en && wr_idx == idx) ? bus.filter_data : weight_q[idx];
    assign rd_valid  = (wr_en && wr_idx == idx) || valid_q[idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        cx_d          = cx_q;
        cy_d          = cy_q;
        dim_d         = dim_q;
        valid_d       = valid_q;
        pair_valid_d  = 1'b0;
        miss_d        = 1'b0;
        pair_pixel_d  = pair_pixel_q;
        pair_weight_d = pair_weight_q;
        pair_index_d  = pair_index_q;
        pair_last_d   = pair_last_q;

        if (bus.center_write_enable) begin
            cx_d  = bus.center_x_input;
            cy_d  = bus.center_y_input;
            dim_d = bus.filter_dim | 3'd1;
        end
        if (wr_en) valid_d[wr_idx] = 1'b1;

        if (!bus.issue_a_blocked && in_win) begin
            if (rd_valid) begin
                pair_valid_d  = 1'b1;
                pair_pixel_d  = bus.issue_a_data;
                pair_weight_d = rd_weight;
                pair_index_d  = idx;
                pair_last_d   = (idx == taps - 6'd1);
            end else begin
                miss_d = 1'b1;
            end
        end
    end

    always_comb begin
        loaded = 1'b1;
        for (int i = 0; i < 49; i++)
            if ((6'(i) < taps) && !valid_q[i]) loaded = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q          <= '0;
            cy_q          <= '0;
            dim_q         <= 3'd1;
            valid_q       <= '0;
            pair_valid_q  <= 1'b0;
            pair_pixel_q  <= '0;
            pair_weight_q <= '0;
            pair_index_q  <= '0;
            pair_last_q   <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            dim_q         <= dim_d;
            valid_q       <= valid_d;
            pair_valid_q  <= pair_valid_d;
            pair_pixel_q  <= pair_pixel_d;
            pair_weight_q <= pair_weight_d;
            pair_index_q  <= pair_index_d;
            pair_last_q   <= pair_last_d;
            miss_q        <= miss_d;
        end
    end

    // NOTE: the weight RAM is not reset; the valid bits alone say which taps are usable.
    always_ff @(posedge clk) begin
        if (wr_en) weight_q[wr_idx] <= bus.filter_data;
    end

`ifdef ALLOC_MISS_COUNT_EN
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        miss_count_d = miss_count_q;
        if (bus.center_write_enable)             miss_count_d = '0;
        else if (miss_d && miss_count_q != '1)   miss_count_d = miss_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) miss_count_q <= '0;
        else     miss_count_q <= miss_count_d;
    end

    assign bus.miss_count = miss_count_q;
`endif

    assign bus.pair_valid    = pair_valid_q;
    assign bus.pair_pixel    = pair_pixel_q;
    assign bus.pair_weight   = pair_weight_q;
    assign bus.pair_index    = pair_index_q;
    assign bus.pair_last     = pair_last_q;
    assign bus.miss          = miss_q;
    assign bus.filter_loaded = loaded;
endmodule

// File: tb/tb_conv_allocator.sv
// Directed self-checking bench for conv_allocator.
// Exercises ALLOC_MISS_COUNT_EN checks only when that macro is defined.
module tb_conv_allocator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   test_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    conv_allocator_if #(.DATA_W(18), .COORD_W(8), .CNT_W(13)) bus ();

    conv_allocator #(.DATA_W(18), .COORD_W(8), .CNT_W(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [7:0] x, input logic [7:0] y, input logic [17:0] d);
        bus.issue_a_x       = x;
        bus.issue_a_y       = y;
        bus.issue_a_data    = d;
        bus.issue_a_blocked = 1'b0;
    endtask

    task automatic set_center(input logic [7:0] x, input logic [7:0] y, input logic [2:0] dim);
        bus.center_x_input      = x;
        bus.center_y_input      = y;
        bus.filter_dim          = dim;
        bus.center_write_enable = 1'b1;
    endtask

    task automatic check_pair(input string tag, input logic [17:0] pix, input logic [17:0] w,
                              input logic [5:0] idx, input logic last);
        check({tag, "_valid"},  32'(bus.pair_valid),  32'd1);
        check({tag, "_pixel"},  32'(bus.pair_pixel),  32'(pix));
        check({tag, "_weight"}, 32'(bus.pair_weight), 32'(w));
        check({tag, "_index"},  32'(bus.pair_index),  32'(idx));
        check({tag, "_last"},   32'(bus.pair_last),   32'(last));
        check({tag, "_miss"},   32'(bus.miss),        32'd0);
    endtask

    initial begin
        bus.issue_a_x            = '0;
        bus.issue_a_y            = '0;
        bus.issue_a_data         = '0;
        bus.issue_a_blocked      = 1'b1;
        bus.filter_issue_counter = '0;
        bus.filter_data          = '0;
        bus.filter_blocked       = 1'b1;
        bus.center_x_input       = '0;
        bus.center_y_input       = '0;
        bus.center_write_enable  = 1'b0;
        bus.filter_dim           = '0;
        #12 rst = 1'b0;

        check("rst_pair_valid", 32'(bus.pair_valid), 32'd0);
        check("rst_miss",       32'(bus.miss),       32'd0);
        check("rst_pair_index", 32'(bus.pair_index), 32'd0);
        check("rst_loaded",     32'(bus.filter_loaded), 32'd0);

        // Centre (1,1), dim 3, nothing loaded: in-window pixel misses.
        set_center(8'd1, 8'd1, 3'd3);
        step();
        bus.center_write_enable = 1'b0;
        pixel(8'd0, 8'd0, 18'd5);
        step();
        check("miss_flag",   32'(bus.miss),          32'd1);
        check("miss_valid",  32'(bus.pair_valid),    32'd0);
        check("miss_loaded", 32'(bus.filter_loaded), 32'd0);
`ifdef ALLOC_MISS_COUNT_EN
        check("miss_count1", 32'(bus.miss_count), 32'd1);
`endif
        bus.issue_a_blocked = 1'b1;
        step();
        check("blocked_miss", 32'(bus.miss), 32'd0);

        // Load taps 0..8 with 1..9.
        bus.filter_blocked = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.filter_issue_counter = 13'(i);
            bus.filter_data          = 18'(i + 1);
            step();
        end
        bus.filter_blocked = 1'b1;
        check("loaded_dim3", 32'(bus.filter_loaded), 32'd1);

        pixel(8'd0, 8'd0, 18'd0);  step(); check_pair("row_x0", 18'd0,  18'd1, 6'd0, 1'b0);
        pixel(8'd1, 8'd0, 18'd10); step(); check_pair("row_x1", 18'd10, 18'd2, 6'd1, 1'b0);
        pixel(8'd2, 8'd0, 18'd20); step(); check_pair("row_x2", 18'd20, 18'd3, 6'd2, 1'b0);
        pixel(8'd3, 8'd0, 18'd30); step();
        check("row_x3_valid", 32'(bus.pair_valid), 32'd0);
        check("row_x3_miss",  32'(bus.miss),       32'd0);
        check("row_x3_hold",  32'(bus.pair_pixel), 32'd20);

        pixel(8'd2, 8'd2, 18'd44); step(); check_pair("last_tap", 18'd44, 18'd9, 6'd8, 1'b1);

        // Same-cycle write of tap 4 and read of tap 4.
        bus.filter_blocked       = 1'b0;
        bus.filter_issue_counter = 13'd4;
        bus.filter_data          = 18'd77;
        pixel(8'd1, 8'd1, 18'd55);
        step();
        check_pair("bypass", 18'd55, 18'd77, 6'd4, 1'b0);
        bus.filter_blocked = 1'b1;
        pixel(8'd1, 8'd1, 18'd56); step(); check_pair("stored", 18'd56, 18'd77, 6'd4, 1'b0);

        // Counter 9 is beyond dim 3 and must not mark tap 9 valid.
        bus.filter_blocked       = 1'b0;
        bus.filter_issue_counter = 13'd9;
        bus.filter_data          = 18'd99;
        bus.issue_a_blocked      = 1'b1;
        step();
        bus.filter_blocked = 1'b1;

        // Centre change alongside a pixel: pixel uses old centre (1,1) dim 3.
        set_center(8'd2, 8'd2, 3'd4);
        pixel(8'd2, 8'd2, 18'd7);
        step();
        bus.center_write_enable = 1'b0;
        check_pair("old_center", 18'd7, 18'd9, 6'd8, 1'b1);
        check("loaded_dim5", 32'(bus.filter_loaded), 32'd0);

        pixel(8'd0, 8'd0, 18'd3); step(); check_pair("dim5_corner", 18'd3, 18'd1, 6'd0, 1'b0);
        pixel(8'd5, 8'd0, 18'd8); step();
        check("dim5_out_valid", 32'(bus.pair_valid), 32'd0);
        check("dim5_out_miss",  32'(bus.miss),       32'd0);
        pixel(8'd4, 8'd1, 18'd9); step();
        check("tap9_ignored_miss",  32'(bus.miss),       32'd1);
        check("tap9_ignored_valid", 32'(bus.pair_valid), 32'd0);
`ifdef ALLOC_MISS_COUNT_EN
        check("miss_count_cleared", 32'(bus.miss_count), 32'd1);
`endif

        // Asynchronous reset in the middle of a pair stream.
        pixel(8'd0, 8'd0, 18'd12); step();
        check("pre_rst_valid", 32'(bus.pair_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",  32'(bus.pair_valid),    32'd0);
        check("async_rst_pixel",  32'(bus.pair_pixel),    32'd0);
        check("async_rst_weight", 32'(bus.pair_weight),   32'd0);
        check("async_rst_index",  32'(bus.pair_index),    32'd0);
        check("async_rst_miss",   32'(bus.miss),          32'd0);
        check("async_rst_loaded", 32'(bus.filter_loaded), 32'd0);
        bus.issue_a_blocked = 1'b1;
        #10 rst = 1'b0;
        step();
        check("post_rst_valid", 32'(bus.pair_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
